// File: rtl/program_ram.sv
// Word-addressed 32-bit RAM for SimpleCPU with a byte-serial program loader that
// holds the CPU in reset until the image has been written.
module program_ram #(
    parameter int ADDR_LEN = 14,
    parameter int DEPTH    = 16384
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wrEn,
    input  logic [ADDR_LEN-1:0] addr_toRAM,
    input  logic [31:0]         data_toRAM,
    output logic [31:0]         data_fromRAM,
    input  logic                load_valid,
    input  logic [7:0]          load_byte,
    input  logic                load_last,
    output logic                load_ready,
    output logic                cpu_rst,
    output logic                load_done,
    output logic                load_err,
    output logic [ADDR_LEN:0]   load_words
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_LEN:0] DEPTH_W = (ADDR_LEN+1)'(DEPTH);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [1:0]          byte_idx_reg;
    logic [31:0]         asm_reg;
    logic [31:0]         asm_next;
    logic [ADDR_LEN:0]   words_reg;
    logic                err_reg;
    logic [31:0]         rd_reg;
    logic [31:0]         mem [DEPTH];

    logic                accept;
    logic                word_done;
    logic                room;
    logic                cpu_in_range;
    logic                we;
    logic [IDX_W-1:0]    wr_idx;
    logic [31:0]         wr_data;

    assign accept       = (state_reg == LOAD) && load_valid;
    assign word_done    = accept && (load_last || (byte_idx_reg == 2'd3));
    assign room         = (words_reg < DEPTH_W);
    assign cpu_in_range = ({1'b0, addr_toRAM} < DEPTH_W);

    // Big-endian packing; bytes below the current index are still zero, which
    // gives the zero padding of a short final word for free.
    always_comb begin
        asm_next = asm_reg;
        case (byte_idx_reg)
            2'd0:    asm_next = {load_byte, 24'h0};
            2'd1:    asm_next = {asm_reg[31:24], load_byte, 16'h0};
            2'd2:    asm_next = {asm_reg[31:16], load_byte, 8'h0};
            default: asm_next = {asm_reg[31:8], load_byte};
        endcase
    end

    // One shared write port: the loader owns it in LOAD, the CPU in RUN.
    always_comb begin
        we      = 1'b0;
        wr_idx  = '0;
        wr_data = asm_next;
        if (state_reg == LOAD) begin
            we     = word_done && room;
            wr_idx = words_reg[IDX_W-1:0];
        end else begin
            we      = wrEn && cpu_in_range;
            wr_idx  = addr_toRAM[IDX_W-1:0];
            wr_data = data_toRAM;
        end
    end

    always_comb begin
        state_next = state_reg;
        if ((state_reg == LOAD) && accept && load_last)
            state_next = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= LOAD;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_reg <= 2'd0;
            asm_reg      <= 32'h0;
            words_reg    <= '0;
            err_reg      <= 1'b0;
        end else if (accept) begin
            if (word_done) begin
                byte_idx_reg <= 2'd0;
                asm_reg      <= 32'h0;
                if (room)
                    words_reg <= words_reg + (ADDR_LEN+1)'(1);
                else
                    err_reg <= 1'b1;
            end else begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
                asm_reg      <= asm_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_idx] <= wr_data;
    end

    // Read-first: a same-cycle write to this address lands after the old word is captured.
    always_ff @(posedge clk) begin
        if (rst)
            rd_reg <= 32'h0;
        else if ((state_reg == RUN) && cpu_in_range)
            rd_reg <= mem[addr_toRAM[IDX_W-1:0]];
        else
            rd_reg <= 32'h0;
    end

    assign data_fromRAM = rd_reg;
    assign load_ready   = (state_reg == LOAD);
    assign cpu_rst      = (state_reg == LOAD);
    assign load_done    = (state_reg == RUN);
    assign load_err     = err_reg;
    assign load_words   = words_reg;

endmodule
